// File: rtl/logic_op_pipe.sv
// Elastic bitwise-operation pipeline: AND/OR/XOR/NAND evaluated at stage-0 entry,
// then carried through G_STAGES valid/ready register stages with a completed-result counter.
module logic_op_pipe #(
  parameter int G_WIDTH  = 8,
  parameter int G_STAGES = 2,
  parameter int G_CNT_W  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [G_WIDTH-1:0] a,
  input  logic [G_WIDTH-1:0] b,
  input  logic [1:0]         op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [G_WIDTH-1:0] c,
  output logic [1:0]         out_op,
  output logic [G_CNT_W-1:0] xfer_cnt
);

  localparam int LAST = G_STAGES - 1;

  generate
    if (G_STAGES < 1 || G_STAGES > 8) begin : g_bad_stages
      $fatal(1, "logic_op_pipe: G_STAGES must be in 1..8");
    end
  endgenerate

  logic [G_STAGES-1:0] valid_reg;
  logic [G_STAGES-1:0] adv;
  logic [G_WIDTH-1:0]  data_reg [G_STAGES];
  logic [1:0]          op_reg   [G_STAGES];
  logic [G_CNT_W-1:0]  xfer_cnt_reg;
  logic [G_WIDTH-1:0]  op_result;

  always_comb begin
    op_result = '0;
    case (op)
      2'b00:   op_result = a & b;
      2'b01:   op_result = a | b;
      2'b10:   op_result = a ^ b;
      default: op_result = ~(a & b);
    endcase
  end

  // Stage k may advance iff some stage at or after k is empty, or the consumer takes
  // the last beat. Written in closed form so the ready chain has no self-dependency.
  generate
    for (genvar gi = 0; gi < G_STAGES; gi++) begin : g_adv
      assign adv[gi] = out_ready || !(&valid_reg[LAST:gi]);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg    <= '0;
      xfer_cnt_reg <= '0;
      for (int k = 0; k < G_STAGES; k++) begin
        data_reg[k] <= '0;
        op_reg[k]   <= '0;
      end
    end else begin
      if (adv[0]) begin
        valid_reg[0] <= in_valid;
        if (in_valid) begin
          data_reg[0] <= op_result;
          op_reg[0]   <= op;
        end
      end
      for (int k = 1; k < G_STAGES; k++) begin
        if (adv[k]) begin
          valid_reg[k] <= valid_reg[k-1];
          if (valid_reg[k-1]) begin
            data_reg[k] <= data_reg[k-1];
            op_reg[k]   <= op_reg[k-1];
          end
        end
      end
      if (valid_reg[LAST] && out_ready) begin
        xfer_cnt_reg <= xfer_cnt_reg + G_CNT_W'(1);
      end
    end
  end

  assign in_ready  = adv[0];
  assign out_valid = valid_reg[LAST];
  assign c         = data_reg[LAST];
  assign out_op    = op_reg[LAST];
  assign xfer_cnt  = xfer_cnt_reg;

endmodule

// File: tb/tb_logic_op_pipe.sv
// Directed/self-checking bench for logic_op_pipe (8-bit, 3 stages), with a second
// 4-bit-counter instance sharing all inputs to exercise counter wrap.
module tb_logic_op_pipe;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic [1:0] op = '0;

  logic        in_ready, out_valid;
  logic [7:0]  c;
  logic [1:0]  out_op;
  logic [15:0] xfer_cnt;

  logic        in_ready4, out_valid4;
  logic [7:0]  c4;
  logic [1:0]  out_op4;
  logic [3:0]  xfer_cnt4;

  int vectors = 0;
  int miscompares = 0;
  logic [9:0] exp_q[$];

  logic_op_pipe #(.G_WIDTH(8), .G_STAGES(3), .G_CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .c(c), .out_op(out_op), .xfer_cnt(xfer_cnt)
  );

  logic_op_pipe #(.G_WIDTH(8), .G_STAGES(3), .G_CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
    .a(a), .b(b), .op(op), .out_valid(out_valid4), .out_ready(out_ready),
    .c(c4), .out_op(out_op4), .xfer_cnt(xfer_cnt4)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ref_c(input logic [7:0] x, input logic [7:0] y, input logic [1:0] o);
    case (o)
      2'd0:    return x & y;
      2'd1:    return x | y;
      2'd2:    return x ^ y;
      default: return ~(x & y);
    endcase
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    exp_q.delete();
    repeat (2) tick;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    repeat (2) tick;
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_hold_valid: got %b expected 0", out_valid); end
    rst_n = 1'b1;
    #1;
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    vectors++;
    if (c !== 8'h00) begin miscompares++; $display("FAIL reset_c: got %h expected 00", c); end
    vectors++;
    if (out_op !== 2'd0) begin miscompares++; $display("FAIL reset_out_op: got %0d expected 0", out_op); end
    vectors++;
    if (xfer_cnt !== 16'd0) begin miscompares++; $display("FAIL reset_xfer_cnt: got %0d expected 0", xfer_cnt); end
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_ops;
    logic [7:0] exp_c [4];
    exp_c[0] = 8'h24;
    exp_c[1] = 8'hBD;
    exp_c[2] = 8'h99;
    exp_c[3] = 8'hDB;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      a = 8'hA5; b = 8'h3C; op = 2'(k); in_valid = 1'b1;
      #1;
      vectors++;
      if (in_ready !== 1'b1) begin miscompares++; $display("FAIL op%0d_in_ready: got %b expected 1", k, in_ready); end
      tick;
      in_valid = 1'b0; a = '0; b = '0; op = '0;
      vectors++;
      if (out_valid !== 1'b0) begin miscompares++; $display("FAIL op%0d_lat1: got out_valid %b expected 0", k, out_valid); end
      tick;
      vectors++;
      if (out_valid !== 1'b0) begin miscompares++; $display("FAIL op%0d_lat2: got out_valid %b expected 0", k, out_valid); end
      tick;
      vectors++;
      if (out_valid !== 1'b1) begin miscompares++; $display("FAIL op%0d_lat3: got out_valid %b expected 1", k, out_valid); end
      vectors++;
      if (c !== exp_c[k]) begin miscompares++; $display("FAIL op%0d_c: got %h expected %h", k, c, exp_c[k]); end
      vectors++;
      if (out_op !== 2'(k)) begin miscompares++; $display("FAIL op%0d_out_op: got %0d expected %0d", k, out_op, k); end
      tick;
      vectors++;
      if (out_valid !== 1'b0) begin miscompares++; $display("FAIL op%0d_drained: got out_valid %b expected 0", k, out_valid); end
    end
    vectors++;
    if (xfer_cnt !== 16'd4) begin miscompares++; $display("FAIL ops_xfer_cnt: got %0d expected 4", xfer_cnt); end
  endtask

  task automatic test_back_to_back;
    int got = 0;
    logic [9:0] e;
    apply_reset();
    out_ready = 1'b1;
    for (int t = 0; t < 53; t++) begin
      if (t < 50) begin
        in_valid = 1'b1; a = 8'($urandom); b = 8'($urandom); op = 2'($urandom_range(0, 3));
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (t < 50) begin
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_in_ready[%0d]: got %b expected 1", t, in_ready); end
      end
      if (out_valid && out_ready) begin
        got++;
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++; $display("FAIL b2b_extra: got op=%0d c=%h expected no result", out_op, c);
        end else begin
          e = exp_q.pop_front();
          if ({out_op, c} !== e) begin miscompares++; $display("FAIL b2b_result: got op=%0d c=%h expected op=%0d c=%h", out_op, c, e[9:8], e[7:0]); end
        end
      end
      if (in_valid && in_ready) exp_q.push_back({op, ref_c(a, b, op)});
      tick;
    end
    vectors++;
    if (got !== 50) begin miscompares++; $display("FAIL b2b_count: got %0d results expected 50", got); end
    vectors++;
    if (xfer_cnt !== 16'd50) begin miscompares++; $display("FAIL b2b_xfer_cnt: got %0d expected 50", xfer_cnt); end
  endtask

  task automatic test_backpressure;
    int acc = 0;
    int got = 0;
    logic stalled = 1'b0;
    logic [7:0] c_hold;
    logic [1:0] op_hold;
    logic [9:0] e;
    out_ready = 1'b0;
    for (int t = 0; t < 8 && !stalled; t++) begin
      in_valid = 1'b1; a = 8'(8'h10 + t); b = 8'hF0; op = 2'(t % 4);
      #1;
      if (in_ready) begin
        exp_q.push_back({op, ref_c(a, b, op)});
        acc++;
        tick;
      end else begin
        stalled = 1'b1;
      end
    end
    vectors++;
    if (acc !== 3) begin miscompares++; $display("FAIL bp_accepts: got %0d expected 3", acc); end
    vectors++;
    if (out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_out_valid: got %b expected 1", out_valid); end
    c_hold = c;
    op_hold = out_op;
    for (int t = 0; t < 3; t++) begin
      tick;
      vectors++;
      if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready_low[%0d]: got %b expected 0", t, in_ready); end
      vectors++;
      if ({out_op, c} !== {op_hold, c_hold}) begin
        miscompares++; $display("FAIL bp_stable[%0d]: got op=%0d c=%h expected op=%0d c=%h", t, out_op, c, op_hold, c_hold);
      end
    end
    out_ready = 1'b1;
    for (int t = 0; t < 12; t++) begin
      if (t < 3) begin
        in_valid = 1'b1; a = 8'(8'h70 + t); b = 8'h11; op = 2'(2 + t % 2);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (t == 0) begin
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_release_in_ready: got %b expected 1", in_ready); end
      end
      if (out_valid && out_ready) begin
        got++;
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++; $display("FAIL bp_extra: got op=%0d c=%h expected no result", out_op, c);
        end else begin
          e = exp_q.pop_front();
          if ({out_op, c} !== e) begin miscompares++; $display("FAIL bp_result: got op=%0d c=%h expected op=%0d c=%h", out_op, c, e[9:8], e[7:0]); end
        end
      end
      if (in_valid && in_ready) exp_q.push_back({op, ref_c(a, b, op)});
      tick;
    end
    vectors++;
    if (got !== 6) begin miscompares++; $display("FAIL bp_drain_count: got %0d expected 6", got); end
  endtask

  task automatic test_random;
    int sent = 0;
    int got = 0;
    logic [9:0] e;
    apply_reset();
    for (int t = 0; t < 8000; t++) begin
      if (sent == 1000 && exp_q.size() == 0) break;
      in_valid = (sent < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
      a = 8'($urandom); b = 8'($urandom); op = 2'($urandom_range(0, 3));
      out_ready = 1'($urandom_range(0, 1));
      #1;
      if (out_valid && out_ready) begin
        got++;
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++; $display("FAIL rnd_extra: got op=%0d c=%h expected no result", out_op, c);
        end else begin
          e = exp_q.pop_front();
          if ({out_op, c} !== e) begin miscompares++; $display("FAIL rnd_result: got op=%0d c=%h expected op=%0d c=%h", out_op, c, e[9:8], e[7:0]); end
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back({op, ref_c(a, b, op)});
        sent++;
      end
      tick;
    end
    vectors++;
    if (got !== 1000) begin miscompares++; $display("FAIL rnd_count: got %0d results expected 1000", got); end
    vectors++;
    if (exp_q.size() != 0) begin miscompares++; $display("FAIL rnd_leftover: got %0d pending expected 0", exp_q.size()); end
    vectors++;
    if (xfer_cnt !== 16'd1000) begin miscompares++; $display("FAIL rnd_xfer_cnt: got %0d expected 1000", xfer_cnt); end
    vectors++;
    if (xfer_cnt4 !== 4'd8) begin miscompares++; $display("FAIL rnd_xfer_cnt4: got %0d expected 8", xfer_cnt4); end
  endtask

  task automatic test_reset_midstream;
    int sent = 0;
    int got = 0;
    logic [9:0] e;
    exp_q.delete();
    out_ready = 1'b0;
    in_valid = 1'b1; a = 8'hC3; b = 8'h5A; op = 2'd1;
    tick;
    a = 8'h81; b = 8'h18; op = 2'd2;
    tick;
    in_valid = 1'b0;
    tick;
    vectors++;
    if ({out_valid, out_op, c} !== {1'b1, 2'd1, 8'hDB}) begin
      miscompares++; $display("FAIL mid_preload: got v=%b op=%0d c=%h expected v=1 op=1 c=db", out_valid, out_op, c);
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL mid_async_valid: got %b expected 0", out_valid); end
    vectors++;
    if (c !== 8'h00) begin miscompares++; $display("FAIL mid_async_c: got %h expected 00", c); end
    vectors++;
    if (out_op !== 2'd0) begin miscompares++; $display("FAIL mid_async_op: got %0d expected 0", out_op); end
    vectors++;
    if (xfer_cnt !== 16'd0) begin miscompares++; $display("FAIL mid_async_cnt: got %0d expected 0", xfer_cnt); end
    #2;
    rst_n = 1'b1;
    tick;
    out_ready = 1'b1;
    for (int t = 0; t < 40; t++) begin
      if (got == 17) break;
      if (sent == 0) begin
        in_valid = 1'b1; a = 8'h0F; b = 8'hF0; op = 2'd1;
      end else if (sent < 17) begin
        in_valid = 1'b1; a = 8'($urandom); b = 8'($urandom); op = 2'($urandom_range(0, 3));
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (out_valid && out_ready) begin
        vectors++;
        if (got == 0 && {out_op, c} !== {2'd1, 8'hFF}) begin
          miscompares++; $display("FAIL mid_first_result: got op=%0d c=%h expected op=1 c=ff", out_op, c);
        end else if (exp_q.size() == 0) begin
          miscompares++; $display("FAIL mid_extra: got op=%0d c=%h expected no result", out_op, c);
        end else begin
          e = exp_q.pop_front();
          if ({out_op, c} !== e) begin miscompares++; $display("FAIL mid_result: got op=%0d c=%h expected op=%0d c=%h", out_op, c, e[9:8], e[7:0]); end
        end
        if (got == 0 && exp_q.size() != 0 && exp_q[0] == {2'd1, 8'hFF}) void'(exp_q.pop_front());
        got++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back({op, ref_c(a, b, op)});
        sent++;
      end
      tick;
    end
    in_valid = 1'b0;
    vectors++;
    if (got !== 17) begin miscompares++; $display("FAIL mid_count: got %0d results expected 17", got); end
    vectors++;
    if (xfer_cnt !== 16'd17) begin miscompares++; $display("FAIL mid_xfer_cnt: got %0d expected 17", xfer_cnt); end
    vectors++;
    if (xfer_cnt4 !== 4'd1) begin miscompares++; $display("FAIL wrap_xfer_cnt4: got %0d expected 1", xfer_cnt4); end
  endtask

  initial begin
    test_reset();
    test_ops();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
